// File: rtl/instr_entry_sequencer.sv
// Switch-driven instruction entry into a small program memory, with
// free-run or single-step replay to the ALU over a valid/ready handshake.
module instr_entry_sequencer #(
    parameter int DATA_W   = 8,
    parameter int OP_W     = 4,
    parameter int REG_ID_W = 3,
    parameter int DEPTH    = 10,
    parameter int ADDR_W   = 4,
    localparam int INSTR_W = OP_W + 2 * REG_ID_W + DATA_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DATA_W-1:0]  inputs,
    input  logic               set_pulse,
    input  logic               exec_pulse,
    input  logic               step_mode,
    input  logic               clear,
    output logic [1:0]         field,
    output logic [ADDR_W-1:0]  count,
    output logic               full,
    output logic               err,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ENTRY,
        RUN,
        STEP_WAIT
    } state_t;

    localparam logic [ADDR_W-1:0] FULL_CNT = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t state, state_n;

    logic [1:0]          field_n;
    logic [ADDR_W-1:0]   count_n;
    logic [ADDR_W-1:0]   pc_n;
    logic                err_n;
    logic                done_n;
    logic [OP_W-1:0]     op, op_n;
    logic [REG_ID_W-1:0] reg1, reg1_n;
    logic [REG_ID_W-1:0] reg2, reg2_n;
    logic                we;

    logic [INSTR_W-1:0] mem [DEPTH];

    assign full        = (count == FULL_CNT);
    assign instr_valid = (state == RUN);
    assign busy        = (state != ENTRY);
    assign instr       = mem[pc];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ENTRY;
            field <= '0;
            count <= '0;
            pc    <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
            op    <= '0;
            reg1  <= '0;
            reg2  <= '0;
        end else begin
            state <= state_n;
            field <= field_n;
            count <= count_n;
            pc    <= pc_n;
            err   <= err_n;
            done  <= done_n;
            op    <= op_n;
            reg1  <= reg1_n;
            reg2  <= reg2_n;
        end
    end

    // Program store is deliberately not reset; count gates visibility.
    always_ff @(posedge clock) begin
        if (we)
            mem[count] <= {op, reg1, reg2, inputs};
    end

    always_comb begin
        state_n = state;
        field_n = field;
        count_n = count;
        pc_n    = pc;
        err_n   = err;
        done_n  = 1'b0;
        op_n    = op;
        reg1_n  = reg1;
        reg2_n  = reg2;
        we      = 1'b0;
        case (state)
            ENTRY: begin
                priority case (1'b1)
                    clear: begin
                        count_n = '0;
                        field_n = '0;
                        err_n   = 1'b0;
                    end
                    exec_pulse: begin
                        field_n = '0;
                        if (count != '0) begin
                            pc_n    = '0;
                            state_n = RUN;
                        end else begin
                            done_n = 1'b1;
                        end
                    end
                    set_pulse: begin
                        case (field)
                            2'd0: begin
                                op_n    = inputs[OP_W-1:0];
                                field_n = 2'd1;
                            end
                            2'd1: begin
                                reg1_n  = inputs[REG_ID_W-1:0];
                                field_n = 2'd2;
                            end
                            2'd2: begin
                                reg2_n  = inputs[REG_ID_W-1:0];
                                field_n = 2'd3;
                            end
                            default: begin
                                field_n = '0;
                                if (full) begin
                                    err_n = 1'b1;
                                end else begin
                                    we      = 1'b1;
                                    count_n = count + ONE;
                                end
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            RUN: begin
                if (instr_ready) begin
                    if (pc == count - ONE) begin
                        done_n  = 1'b1;
                        pc_n    = '0;
                        state_n = ENTRY;
                    end else begin
                        pc_n = pc + ONE;
                        if (step_mode)
                            state_n = STEP_WAIT;
                    end
                end
            end
            STEP_WAIT: begin
                if (exec_pulse)
                    state_n = RUN;
            end
            default: state_n = ENTRY;
        endcase
    end

endmodule

// File: tb/tb_instr_entry_sequencer.sv
// Self-checking bench: vector table, directed corner sequences and
// randomized traffic checked against a queue-based program model.
module tb_instr_entry_sequencer;

    localparam int DEPTH = 10;

    logic        clock;
    logic        reset;
    logic [7:0]  inputs;
    logic        set_pulse;
    logic        exec_pulse;
    logic        step_mode;
    logic        clear;
    logic [1:0]  field;
    logic [3:0]  count;
    logic        full;
    logic        err;
    logic        instr_valid;
    logic [17:0] instr;
    logic        instr_ready;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    instr_entry_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .inputs      (inputs),
        .set_pulse   (set_pulse),
        .exec_pulse  (exec_pulse),
        .step_mode   (step_mode),
        .clear       (clear),
        .field       (field),
        .count       (count),
        .full        (full),
        .err         (err),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nvec;
    int nmis;
    int dcount;
    int vcount;

    // Reference model: the program is a queue; replay position is an index.
    logic [17:0] prog [$];
    int  m_field;
    int  m_pc;
    bit  m_err;
    bit  m_run;
    bit  m_wait;
    bit  m_done;
    logic [3:0] m_op;
    logic [2:0] m_r1;
    logic [2:0] m_r2;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        prog.delete();
        m_field = 0;
        m_pc    = 0;
        m_err   = 0;
        m_run   = 0;
        m_wait  = 0;
        m_done  = 0;
        m_op    = '0;
        m_r1    = '0;
        m_r2    = '0;
    endtask

    task automatic model_step();
        m_done = 0;
        if (!m_run && !m_wait) begin
            if (clear) begin
                prog.delete();
                m_field = 0;
                m_err   = 0;
            end else if (exec_pulse) begin
                m_field = 0;
                if (prog.size() > 0) begin
                    m_pc  = 0;
                    m_run = 1;
                end else begin
                    m_done = 1;
                end
            end else if (set_pulse) begin
                case (m_field)
                    0: m_op = inputs[3:0];
                    1: m_r1 = inputs[2:0];
                    2: m_r2 = inputs[2:0];
                    default: begin
                        if (prog.size() == DEPTH)
                            m_err = 1;
                        else
                            prog.push_back({m_op, m_r1, m_r2, inputs});
                    end
                endcase
                m_field = (m_field + 1) % 4;
            end
        end else if (m_run) begin
            if (instr_ready) begin
                if (m_pc == prog.size() - 1) begin
                    m_done = 1;
                    m_pc   = 0;
                    m_run  = 0;
                end else begin
                    m_pc++;
                    if (step_mode) begin
                        m_run  = 0;
                        m_wait = 1;
                    end
                end
            end
        end else if (exec_pulse) begin
            m_wait = 0;
            m_run  = 1;
        end
    endtask

    task automatic model_cmp();
        chk("field", 32'(field), 32'(m_field));
        chk("count", 32'(count), 32'(prog.size()));
        chk("full", 32'(full), 32'(prog.size() == DEPTH));
        chk("err", 32'(err), 32'(m_err));
        chk("valid", 32'(instr_valid), 32'(m_run));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("busy", 32'(busy), 32'(m_run | m_wait));
        chk("done", 32'(done), 32'(m_done));
        if (m_run)
            chk("instr", 32'(instr), 32'(prog[m_pc]));
    endtask

    task automatic apply(input logic [7:0] si, input bit s, input bit e,
                         input bit c, input bit st, input bit r);
        @(negedge clock);
        inputs      = si;
        set_pulse   = s;
        exec_pulse  = e;
        clear       = c;
        step_mode   = st;
        instr_ready = r;
        @(posedge clock);
        model_step();
        #1;
        model_cmp();
        if (done) dcount++;
        if (instr_valid) vcount++;
    endtask

    task automatic enter(input logic [3:0] op, input logic [2:0] r1,
                         input logic [2:0] r2, input logic [7:0] imm);
        apply({4'h0, op}, 1, 0, 0, 0, 0);
        apply({5'h0, r1}, 1, 0, 0, 0, 0);
        apply({5'h0, r2}, 1, 0, 0, 0, 0);
        apply(imm, 1, 0, 0, 0, 0);
    endtask

    task automatic idle(input bit r);
        apply(8'h00, 0, 0, 0, 0, r);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  si;
        bit          s, e, c, st, r;
        int          f, cnt, v, p, d;
        logic [17:0] ins;
    } vec_t;

    vec_t tv [7];

    initial begin
        logic [17:0] pack0;
        nvec   = 0;
        nmis   = 0;
        dcount = 0;
        vcount = 0;
        pack0  = {4'h3, 3'd2, 3'd5, 8'hA7};

        tv[0] = '{8'h03, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, '0};
        tv[1] = '{8'h02, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, '0};
        tv[2] = '{8'h05, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, '0};
        tv[3] = '{8'hA7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, '0};
        tv[4] = '{8'h00, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, pack0};
        tv[5] = '{8'h00, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, '0};
        tv[6] = '{8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, '0};

        inputs      = '0;
        set_pulse   = 0;
        exec_pulse  = 0;
        clear       = 0;
        step_mode   = 0;
        instr_ready = 0;
        reset       = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        chk("reset_field", 32'(field), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Packing and a one-instruction replay
        for (int i = 0; i < 7; i++) begin
            apply(tv[i].si, tv[i].s, tv[i].e, tv[i].c, tv[i].st, tv[i].r);
            chk($sformatf("tv%0d_field", i), 32'(field), 32'(tv[i].f));
            chk($sformatf("tv%0d_count", i), 32'(count), 32'(tv[i].cnt));
            chk($sformatf("tv%0d_valid", i), 32'(instr_valid), 32'(tv[i].v));
            chk($sformatf("tv%0d_pc", i), 32'(pc), 32'(tv[i].p));
            chk($sformatf("tv%0d_done", i), 32'(done), 32'(tv[i].d));
            if (tv[i].v != 0)
                chk($sformatf("tv%0d_instr", i), 32'(instr), 32'(tv[i].ins));
        end

        // Free-run, three instructions back to back
        apply(8'h00, 0, 0, 1, 0, 0);
        enter(4'h1, 3'd1, 3'd2, 8'h11);
        enter(4'h2, 3'd3, 3'd4, 8'h22);
        enter(4'h3, 3'd5, 3'd6, 8'h33);
        dcount = 0;
        vcount = 0;
        apply(8'h00, 0, 1, 0, 0, 1);
        repeat (4) idle(1);
        chk("frun_valid_cycles", 32'(vcount), 32'd3);
        chk("frun_done_pulses", 32'(dcount), 32'd1);
        chk("frun_busy", 32'(busy), 32'd0);

        // Backpressure holds instr and pc
        apply(8'h00, 0, 1, 0, 0, 0);
        repeat (4) idle(0);
        chk("bp_pc", 32'(pc), 32'd0);
        chk("bp_instr", 32'(instr), 32'(prog[0]));
        idle(1);
        chk("bp_pc_adv", 32'(pc), 32'd1);
        idle(0);
        chk("bp_pc_hold", 32'(pc), 32'd1);
        repeat (3) idle(1);

        // Single-step with two instructions
        apply(8'h00, 0, 0, 1, 0, 0);
        enter(4'hA, 3'd7, 3'd0, 8'h5C);
        enter(4'hB, 3'd1, 3'd6, 8'hC5);
        apply(8'h00, 0, 1, 0, 1, 0);
        apply(8'h00, 0, 0, 0, 1, 1);
        chk("step_wait_valid", 32'(instr_valid), 32'd0);
        chk("step_wait_pc", 32'(pc), 32'd1);
        apply(8'h00, 0, 0, 0, 1, 1);
        apply(8'h00, 0, 1, 0, 1, 0);
        chk("step_pc1_valid", 32'(instr_valid), 32'd1);
        apply(8'h00, 0, 0, 0, 1, 1);
        chk("step_done", 32'(done), 32'd1);

        // Overfill, then clear, then empty run
        apply(8'h00, 0, 0, 1, 0, 0);
        for (int i = 0; i <= DEPTH; i++)
            enter(4'(i), 3'(i), 3'(i + 1), 8'(8'h40 + i));
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_flag", 32'(full), 32'd1);
        chk("full_err", 32'(err), 32'd1);
        apply(8'h00, 0, 1, 0, 0, 1);
        repeat (DEPTH) idle(1);
        apply(8'h00, 0, 0, 1, 0, 0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        vcount = 0;
        apply(8'h00, 0, 1, 0, 0, 1);
        chk("empty_done", 32'(done), 32'd1);
        idle(1);
        chk("empty_no_valid", 32'(vcount), 32'd0);

        // Reset in the middle of a run
        enter(4'h5, 3'd2, 3'd3, 8'h99);
        apply(8'h00, 0, 1, 0, 0, 0);
        do_reset();

        // set and exec together: run starts, field not advanced
        enter(4'h6, 3'd4, 3'd1, 8'h0F);
        apply(8'h06, 1, 0, 0, 0, 0);
        apply(8'h03, 1, 1, 0, 0, 0);
        chk("same_field", 32'(field), 32'd0);
        chk("same_valid", 32'(instr_valid), 32'd1);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            apply(8'($urandom), $urandom_range(0, 9) < 5,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 99) < 2,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
